// File: rtl/ibuf_rdata_writer.sv
// ---------------------------------------------------------------------------
// ibuf_rdata_writer
//
// Accepts AXI read-data beats for the input-buffer address generator's
// bursts and packs them row by row into a ping-pong input-buffer SRAM
// (2 banks x LM rows x BURST words). One burst fills one block row; after LM
// rows the bank is marked full, blk_ready pulses and filling moves to the
// other bank. The convolution engine frees a bank with bank_release. When
// the bank being filled is still full, rready is held low.
//
// Optional feature (compile-time macro IBUF_BEAT_CHK_EN):
//   Sticky burst-length checker driving err. Without the macro, err is tied 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   flush        in   synchronous clear of pointers/counters/full flags
//   rdata        in   [DW-1:0] AXI read data
//   rvalid       in   AXI read data valid
//   rlast        in   AXI last beat of burst
//   rready       out  AXI read data ready (combinational)
//   wr_en        out  SRAM write enable
//   wr_addr      out  [RW+CW:0] SRAM address {bank, row, col}
//   wr_data      out  [DW-1:0] SRAM write data
//   blk_ready    out  one-cycle pulse: a bank just became full
//   bank_full    out  [1:0] per-bank full flags
//   rd_bank      out  bank the engine must read next
//   bank_release in   pulse: engine finished rd_bank
//   err          out  sticky burst-length error
// ---------------------------------------------------------------------------
module ibuf_rdata_writer #(
  parameter int DW     = 16,
  parameter int BURST  = 32,
  parameter int STRIDE = 2,
  parameter int POY    = 3,
  parameter int LM     = (STRIDE + 1) * POY - STRIDE,
  parameter int RW     = $clog2(LM),
  parameter int CW     = $clog2(BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [DW-1:0]    rdata,
  input  logic             rvalid,
  input  logic             rlast,
  output logic             rready,
  output logic             wr_en,
  output logic [RW+CW:0]   wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             blk_ready,
  output logic [1:0]       bank_full,
  output logic             rd_bank,
  input  logic             bank_release,
  output logic             err
);

  localparam logic [RW-1:0] LAST_ROW = RW'(LM - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(BURST - 1);

  logic          wbank;
  logic          rbank;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          blk_done;
  logic [1:0]    full_next;

  // Ready depends only on the bank currently being filled; reset and flush
  // also block acceptance so no beat of a discarded burst is ever written.
  assign rready   = rst_n & ~flush & ~bank_full[wbank];
  assign accept   = rvalid & rready;
  assign blk_done = accept & rlast & (row == LAST_ROW);
  assign rd_bank  = rbank;

  // Fill and release always touch different banks (the fill bank is never
  // full), so both updates can be merged into one next-state vector.
  // NOTE: default assignment first so every path assigns full_next and no
  // latch is inferred.
  always_comb begin
    full_next = bank_full;
    if (bank_release && bank_full[rbank]) full_next[rbank] = 1'b0;
    if (blk_done)                         full_next[wbank] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      row       <= '0;
      col       <= '0;
      bank_full <= 2'b00;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      blk_ready <= 1'b0;
    end else begin
      bank_full <= full_next;
      blk_ready <= blk_done;
      wr_en     <= accept;

      if (bank_release && bank_full[rbank]) rbank <= ~rbank;

      if (accept) begin
        wr_addr <= {wbank, row, col};
        wr_data <= rdata;

        // rlast ends the row early; otherwise col wraps modulo BURST.
        if (rlast || col == LAST_COL) col <= '0;
        else                          col <= col + 1'b1;

        if (rlast) begin
          if (row == LAST_ROW) begin
            row   <= '0;
            wbank <= ~wbank;
          end else begin
            row <= row + 1'b1;
          end
        end
      end
    end
  end

`ifdef IBUF_BEAT_CHK_EN
  // Sticky until reset; flush deliberately leaves a recorded error visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (!flush && accept) begin
      if ((rlast && col != LAST_COL) || (!rlast && col == LAST_COL))
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ibuf_rdata_writer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ibuf_rdata_writer. Random data and idle gaps are
// driven through directed phases (fill, stall, release, overlap, flush,
// short burst); a block-level reference model predicts every output.
// ---------------------------------------------------------------------------
module tb_ibuf_rdata_writer;

  localparam int DW    = 16;
  localparam int BURST = 32;
  localparam int LM    = 7;
`ifdef IBUF_BEAT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rlast;
  logic          rready;
  logic          wr_en;
  logic [8:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          blk_ready;
  logic [1:0]    bank_full;
  logic          rd_bank;
  logic          bank_release;
  logic          err;

  ibuf_rdata_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rlast        (rlast),
    .rready       (rready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .blk_ready    (blk_ready),
    .bank_full    (bank_full),
    .rd_bank      (rd_bank),
    .bank_release (bank_release),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: beat position inside the current row/block, which bank
  // is filling and which the engine reads, and what the last write was.
  int m_col, m_row, m_wb, m_rb;
  bit m_full [2];
  bit m_err;
  bit e_wr_en, e_blk;
  int e_addr, e_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear(input bit hard);
    m_col = 0; m_row = 0; m_wb = 0; m_rb = 0;
    m_full[0] = 0; m_full[1] = 0;
    e_wr_en = 0; e_blk = 0; e_addr = 0; e_data = 0;
    if (hard) m_err = 0;
  endtask

  // One clock: drive inputs, check rready, advance model on the edge,
  // then check the registered outputs 1 ns after the edge.
  task automatic cycle(input bit v, input bit l, input logic [DW-1:0] d,
                       input bit rel, output bit acc);
    bit exp_rdy;
    rvalid = v; rlast = l; rdata = d; bank_release = rel;
    #1;
    exp_rdy = rst_n && !flush && !m_full[m_wb];
    check("rready", {31'd0, rready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (!rst_n || flush) begin
      model_clear(!rst_n);
    end else begin
      e_wr_en = acc;
      e_blk   = 0;
      if (rel && m_full[m_rb]) begin
        m_full[m_rb] = 0;
        m_rb = 1 - m_rb;
      end
      if (acc) begin
        e_addr = m_wb * 256 + m_row * BURST + m_col;
        e_data = d;
        if (CHK && ((l && m_col != BURST - 1) || (!l && m_col == BURST - 1))) m_err = 1;
        if (l) begin
          m_col = 0;
          if (m_row == LM - 1) begin
            m_row = 0;
            m_full[m_wb] = 1;
            m_wb = 1 - m_wb;
            e_blk = 1;
          end else begin
            m_row++;
          end
        end else begin
          m_col = (m_col + 1) % BURST;
        end
      end
    end
    #1;
    check("wr_en",     {31'd0, wr_en},     {31'd0, e_wr_en});
    check("wr_addr",   {23'd0, wr_addr},   e_addr);
    check("wr_data",   {16'd0, wr_data},   e_data);
    check("blk_ready", {31'd0, blk_ready}, {31'd0, e_blk});
    check("bank_full", {30'd0, bank_full}, {30'd0, m_full[1], m_full[0]});
    check("rd_bank",   {31'd0, rd_bank},   m_rb);
    check("err",       {31'd0, err},       {31'd0, m_err});
  endtask

  // Send nbeats beats with rlast on beat index last_at (-1: none), with
  // optional random idle gaps; optionally pulse bank_release with rlast.
  task automatic send_burst(input int nbeats, input int last_at,
                            input bit rel_last, input bit gaps);
    bit acc, dummy;
    int tries;
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      acc = 0; tries = 0;
      d = DW'($urandom);
      while (!acc) begin
        if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, DW'($urandom), 1'b0, dummy);
        cycle(1'b1, b == last_at, d, rel_last && b == last_at, acc);
        tries++;
        if (!acc && tries > 40) begin
          check("accept_timeout", 32'd0, 32'd1);
          return;
        end
      end
    end
  endtask

  initial begin
    bit a;
    rst_n = 1'b0; flush = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = '0; bank_release = 1'b0;
    model_clear(1'b1);

    // Reset state.
    repeat (2) cycle(1'b1, 1'b0, 16'h1234, 1'b0, a);
    rst_n = 1'b1;

    // Fill bank 0: 224 writes to 0x000..0x0DF, blk_ready on the last one.
    repeat (LM) send_burst(BURST, BURST - 1, 1'b0, 1'b1);
    check("blk0_full", {30'd0, bank_full}, 32'h1);

    // Fill bank 1: 0x100..0x1DF; both banks then full.
    repeat (LM) send_burst(BURST, BURST - 1, 1'b0, 1'b1);
    check("both_full", {30'd0, bank_full}, 32'h3);

    // Stall: beats offered while both banks are full are dropped.
    repeat (5) cycle(1'b1, 1'b0, DW'($urandom), 1'b0, a);
    cycle(1'b1, 1'b0, DW'($urandom), 1'b1, a);
    check("release_full", {30'd0, bank_full}, 32'h2);
    check("release_rd_bank", {31'd0, rd_bank}, 32'h1);

    // Stalled burst resumes into bank 0 from 0x000; finish bank 0.
    repeat (LM) send_burst(BURST, BURST - 1, 1'b0, 1'b0);
    check("refill_full", {30'd0, bank_full}, 32'h3);

    // Free bank 1, then fill it with a release of bank 0 on the final rlast.
    cycle(1'b0, 1'b0, '0, 1'b1, a);
    repeat (LM - 1) send_burst(BURST, BURST - 1, 1'b0, 1'b1);
    send_burst(BURST, BURST - 1, 1'b1, 1'b1);
    check("overlap_full", {30'd0, bank_full}, 32'h2);

    // Flush mid-burst after 10 beats, then a clean burst from 0x000.
    send_burst(10, -1, 1'b0, 1'b1);
    flush = 1'b1;
    cycle(1'b1, 1'b0, DW'($urandom), 1'b0, a);
    flush = 1'b0;
    check("flush_full", {30'd0, bank_full}, 32'h0);
    send_burst(BURST, BURST - 1, 1'b0, 1'b1);

    // Short burst: rlast on beat 20 of 32; err stays across a flush.
    send_burst(20, 19, 1'b0, 1'b0);
    check("short_err", {31'd0, err}, {31'd0, CHK});
    flush = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b0, a);
    flush = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b0, a);
    check("err_after_flush", {31'd0, err}, {31'd0, CHK});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ibuf_rdata_writer.md
Name: ibuf_rdata_writer

Overview:
- Downstream companion of the input-buffer address generator.
- Accepts AXI read-data beats returned for that block's bursts.
- Packs them row by row into a ping-pong input-buffer SRAM: 2 banks x LM rows x BURST words.
- Signals the convolution engine when a full block (LM rows) is resident.
- Frees a bank when the engine releases it; applies backpressure via rready when no bank is free.

Parameters:
- DW, 16, feature-map word width (bits) of rdata and wr_data.
- BURST, 32, beats per read burst; one burst = one block row.
- STRIDE, 2, convolution stride.
- POY, 3, output rows per block.
- LM, ((STRIDE+1)*POY-STRIDE) = 7, rows per block.
- RW, $clog2(LM) = 3, row index width.
- CW, $clog2(BURST) = 5, column index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of pointers/counters/full flags (new feature map).
- rdata  in  DW  AXI read data.
- rvalid  in  1  AXI read data valid.
- rlast  in  1  AXI last beat of burst.
- rready  out  1  AXI read data ready.
- wr_en  out  1  SRAM write enable.
- wr_addr  out  1+RW+CW  SRAM address {bank, row, col}.
- wr_data  out  DW  SRAM write data.
- blk_ready  out  1  one-cycle pulse: a bank just became full.
- bank_full  out  2  per-bank full flags.
- rd_bank  out  1  bank the engine must read next.
- bank_release  in  1  pulse: engine finished rd_bank.
- err  out  1  sticky burst-length error (see Optional Feature).

Behaviour:
- Reset (rst_n=0) or flush=1, next edge:
  - wbank=0, rbank=0, row=0, col=0, bank_full=2'b00.
  - wr_en=0, wr_addr=0, wr_data=0, blk_ready=0.
  - err=0 on reset only; flush does not clear err.
  - An in-flight burst is discarded; no write completes from it.
- rready = rst_n & ~flush & ~bank_full[wbank]; combinational.
- Beat accepted when rvalid & rready. Beats with rready=0 are neither written nor counted.
- Write pipeline, 1-cycle latency:
  - Edge after acceptance: wr_en=1, wr_addr={wbank,row,col} sampled at acceptance, wr_data=rdata.
  - Otherwise wr_en=0; wr_addr/wr_data hold their last value.
- col:
  - Increments per accepted beat.
  - Returns to 0 on an accepted rlast beat.
  - Also wraps to 0 after BURST-1 (modulo BURST).
- row:
  - Increments only on an accepted rlast beat.
  - On an accepted rlast beat with row==LM-1: row->0, bank_full[wbank]<=1, wbank flips, blk_ready pulses.
  - blk_ready asserts in the same cycle as the final wr_en of the block.
- Release:
  - bank_release=1 with bank_full[rbank]=1: clear bank_full[rbank], flip rbank.
  - bank_release with bank_full[rbank]=0: ignored.
- Simultaneous fill and release touch different banks (the fill bank is never full); both take effect the same edge.
- Full stall:
  - Both banks full -> rready=0 until a release.
  - rready rises in the cycle after the release edge.
- rd_bank = rbank (registered).
- Row/col arithmetic is unsigned; bank index wraps modulo 2.

Optional Feature:
- Macro IBUF_BEAT_CHK_EN.
- Defined:
  - err sets (sticky until reset) when an accepted rlast arrives with col!=BURST-1.
  - err also sets when an accepted beat with col==BURST-1 has rlast=0.
  - Data path is unchanged: row still advances only on rlast.
- Undefined: err tied 0; no checker logic.

Test Plan:
- Reset, then 7 bursts of 32 beats, rdata=row*32+col, rvalid held high:
  - 224 wr_en pulses; addresses 0x000..0x0DF.
  - blk_ready on the 224th write; bank_full=01; wbank=1.
- Continue 7 more bursts:
  - Writes to bank 1 (addresses 0x100..0x1DF); bank_full=11.
  - rready=0; an 8th burst stalls with no writes.
- In the stall, pulse bank_release:
  - bank_full=10, rd_bank=1; rready=1 next cycle.
  - Stalled burst writes to 0x000 onward.
- bank_release on the cycle of the final rlast of bank 1, with bank 0 full:
  - bank 0 freed and bank 1 filled on the same edge; bank_full=10; blk_ready pulses.
- Flush mid-burst after 10 beats:
  - Pointers zero, bank_full=00.
  - Next burst writes from address 0x000; err unchanged.
- With IBUF_BEAT_CHK_EN, rlast on beat 20 of 32: err=1 and remains 1 after flush. Without the macro: err stays 0.
